// File: rtl/ir_regbank_pkg.sv
// ----------------------------------------------------------------------------
// ir_regbank_pkg
// Shared definitions for the instruction register bank:
//   `DATA_WIDTH        default word width (16)
//   `IR_SLICE(idx, w)  part-select for slot idx of a packed per-port bus
//   ir_state_e         load/work state encoding (LINIT, LREAD_MEM, LWORK)
// No ports; imported by ir_regbank and ir_regbank_array.
// ----------------------------------------------------------------------------
`ifndef IR_REGBANK_DEFS
`define IR_REGBANK_DEFS
`define DATA_WIDTH 16
`define IR_SLICE(idx, w) ((idx)*(w)) +: (w)
`endif

package ir_regbank_pkg;

    typedef enum logic [1:0] {
        LINIT     = 2'd0,
        LREAD_MEM = 2'd1,
        LWORK     = 2'd2
    } ir_state_e;

    localparam int IR_DEF_DEPTH  = 16;
    localparam int IR_DEF_NUM_RD = 2;
    localparam int IR_MAX_NUM_RD = 4;

    // True when a load counter value addresses the final entry of the bank.
    function automatic logic ir_is_last(input int unsigned cnt, input int unsigned depth);
        return (cnt == depth - 1);
    endfunction

endpackage

// File: rtl/ir_regbank_array.sv
// ----------------------------------------------------------------------------
// ir_regbank_array
// DEPTH x DATA_WIDTH storage with one synchronous write port and NUM_RD
// registered read ports. A read of the address being written in the same
// cycle returns the write data (write-first bypass).
// Ports:
//   clk, rst                 clock, async active-high reset (read regs only)
//   i_wr_en/i_wr_addr/i_wr_data   write port
//   i_rd_en[NUM_RD]          per-port read strobe
//   i_rd_addr                packed per-port read addresses
//   o_rd_data                packed per-port registered read data
//   o_rd_valid[NUM_RD]       per-port valid, one cycle after the strobe
// ----------------------------------------------------------------------------
`ifndef IR_REGBANK_DEFS
`define IR_REGBANK_DEFS
`define DATA_WIDTH 16
`define IR_SLICE(idx, w) ((idx)*(w)) +: (w)
`endif

module ir_regbank_array
    import ir_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH      = IR_DEF_DEPTH,
    parameter int NUM_RD     = IR_DEF_NUM_RD,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic [NUM_RD-1:0]            i_rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_valid
);

    // Storage is deliberately not reset; it is always reloaded before use.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_data;
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_valid;

        assign w_addr = i_rd_addr[`IR_SLICE(p, ADDR_WIDTH)];

        // Write-first: same-cycle write to this address wins over the array.
        assign w_data = (i_wr_en && (i_wr_addr == w_addr)) ? i_wr_data : r_mem[w_addr];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= i_rd_en[p];
                if (i_rd_en[p]) begin
                    r_data <= w_data;
                end
            end
        end

        assign o_rd_data[`IR_SLICE(p, DATA_WIDTH)] = r_data;
        assign o_rd_valid[p]                       = r_valid;
    end

endmodule

// File: rtl/ir_regbank.sv
// ----------------------------------------------------------------------------
// ir_regbank
// Instruction register bank. After reset (or an i_init_start pulse while
// working) it fetches every entry from instruction memory with a req/ack
// handshake, then serves NUM_RD registered read ports and one write port.
// Ports:
//   clk, rst                       clock, async active-high reset
//   i_regfile_en                   global enable for reads/writes in LWORK
//   i_init_start                   reload request (honoured only in LWORK)
//   o_mem_req/o_mem_addr           memory fetch request and word index
//   i_mem_ack/i_mem_data           fetched word strobe and data
//   i_wr_en/i_wr_addr/i_wr_data    write port
//   i_rd_en/i_rd_addr              per-port read strobes, packed addresses
//   o_rd_data/o_rd_valid           per-port registered read data and valid
//   o_init_done                    contents loaded, bank in LWORK
// ----------------------------------------------------------------------------
`ifndef IR_REGBANK_DEFS
`define IR_REGBANK_DEFS
`define DATA_WIDTH 16
`define IR_SLICE(idx, w) ((idx)*(w)) +: (w)
`endif

module ir_regbank
    import ir_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH      = IR_DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_RD     = IR_DEF_NUM_RD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_regfile_en,
    input  logic                         i_init_start,
    output logic                         o_mem_req,
    output logic [ADDR_WIDTH-1:0]        o_mem_addr,
    input  logic                         i_mem_ack,
    input  logic [DATA_WIDTH-1:0]        i_mem_data,
    input  logic                         i_wr_en,
    input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic [NUM_RD-1:0]            i_rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_valid,
    output logic                         o_init_done
);

    ir_state_e             r_state;
    ir_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  w_cnt_last;
    logic                  r_mem_req;
    logic                  r_init_done;
    logic                  w_mem_req_nxt;
    logic                  w_init_done_nxt;

    logic                  w_ack_fire;
    logic                  w_work_en;
    logic                  w_arr_we;
    logic [ADDR_WIDTH-1:0] w_arr_waddr;
    logic [DATA_WIDTH-1:0] w_arr_wdata;
    logic [NUM_RD-1:0]     w_arr_rd_en;

    assign w_cnt_last = ir_is_last(32'(r_cnt), DEPTH);

    // State and load counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LINIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. The counter stops at DEPTH-1 and only returns to 0
    // through LINIT (or on the reload request that leads there).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            LINIT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = LREAD_MEM;
            end
            LREAD_MEM: begin
                if (i_mem_ack) begin
                    if (w_cnt_last) begin
                        w_state_nxt = LWORK;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            LWORK: begin
                if (i_init_start) begin
                    w_state_nxt = LINIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = LINIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state so the flags register in step with it.
    always_comb begin
        w_mem_req_nxt   = (w_state_nxt == LREAD_MEM);
        w_init_done_nxt = (w_state_nxt == LWORK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_cnt;
    assign o_init_done = r_init_done;

    // The array has a single write port shared by the loader and the user;
    // the two are never active in the same state.
    assign w_ack_fire  = (r_state == LREAD_MEM) && i_mem_ack;
    assign w_work_en   = (r_state == LWORK) && i_regfile_en;
    assign w_arr_we    = w_ack_fire || (w_work_en && i_wr_en);
    assign w_arr_waddr = w_ack_fire ? r_cnt : i_wr_addr;
    assign w_arr_wdata = w_ack_fire ? i_mem_data : i_wr_data;
    assign w_arr_rd_en = i_rd_en & {NUM_RD{w_work_en}};

    ir_regbank_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .NUM_RD     (NUM_RD),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_arr_we),
        .i_wr_addr  (w_arr_waddr),
        .i_wr_data  (w_arr_wdata),
        .i_rd_en    (w_arr_rd_en),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid)
    );

endmodule

// File: tb/tb_ir_regbank.sv
`timescale 1ns/1ps
module tb_ir_regbank;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NRD   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_regfile_en = 1'b0;
    logic              i_init_start = 1'b0;
    logic              o_mem_req;
    logic [AW-1:0]     o_mem_addr;
    logic              i_mem_ack = 1'b0;
    logic [DW-1:0]     i_mem_data = '0;
    logic              i_wr_en = 1'b0;
    logic [AW-1:0]     i_wr_addr = '0;
    logic [DW-1:0]     i_wr_data = '0;
    logic [NRD-1:0]    i_rd_en = '0;
    logic [NRD*AW-1:0] i_rd_addr = '0;
    logic [NRD*DW-1:0] o_rd_data;
    logic [NRD-1:0]    o_rd_valid;
    logic              o_init_done;

    ir_regbank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NRD)) dut (
        .clk(clk), .rst(rst), .i_regfile_en(i_regfile_en), .i_init_start(i_init_start),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
        .i_mem_data(i_mem_data), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_init_done(o_init_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference contents of the bank and whether the bank is serving requests.
    logic [DW-1:0] model [DEPTH];
    bit            in_work = 1'b0;

    typedef struct {
        int          due;
        logic [DW-1:0] d;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-port monitor: a queued response must appear exactly on its due cycle;
    // otherwise the port must be idle and hold its last data.
    for (genvar p = 0; p < NRD; p++) begin : g_mon
        exp_t          q[$];
        exp_t          e;
        logic [DW-1:0] last;
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                last = '0;
            end else if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk($sformatf("rd_valid[%0d]", p), 32'(o_rd_valid[p]), 32'd1);
                chk($sformatf("rd_data[%0d]", p), 32'(o_rd_data[p*DW +: DW]), 32'(e.d));
                last = e.d;
            end else begin
                chk($sformatf("idle_valid[%0d]", p), 32'(o_rd_valid[p]), 32'd0);
                chk($sformatf("hold_data[%0d]", p), 32'(o_rd_data[p*DW +: DW]), 32'(last));
            end
        end
    end

    task automatic push(input int p, input logic [DW-1:0] d);
        exp_t e;
        e.due = cyc + 1;
        e.d   = d;
        if (p == 0) g_mon[0].q.push_back(e);
        else        g_mon[1].q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of user traffic; expectations follow the bank's rules.
    task automatic drive(input logic en, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [NRD-1:0] re,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        logic [AW-1:0] ra [NRD];
        ra[0] = ra0;
        ra[1] = ra1;
        i_regfile_en = en;
        i_wr_en      = we;
        i_wr_addr    = wa;
        i_wr_data    = wd;
        i_rd_en      = re;
        i_rd_addr    = {ra1, ra0};
        if (in_work && en) begin
            for (int p = 0; p < NRD; p++)
                if (re[p]) push(p, (we && wa == ra[p]) ? wd : model[ra[p]]);
            if (we) model[wa] = wd;
        end
        step();
    endtask

    task automatic rand_traffic(input int n);
        for (int i = 0; i < n; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
                  NRD'($urandom), AW'($urandom), AW'($urandom));
    endtask

    // Acts as instruction memory: word i = base+i, acked on every (k+1)-th
    // request cycle. Random user traffic and reload pulses are applied
    // meanwhile and must have no effect. Optionally resets at address abort_at.
    task automatic do_load(input logic [DW-1:0] base, input int k, input int exp_n, input int abort_at);
        int n   = 0;
        int idx = 0;
        int c   = 0;
        bit done = 1'b0;
        i_mem_ack = 1'b0;
        while (!done) begin
            i_regfile_en = 1'($urandom);
            i_wr_en      = 1'($urandom);
            i_wr_addr    = AW'($urandom);
            i_wr_data    = DW'($urandom);
            i_rd_en      = NRD'($urandom);
            i_rd_addr    = (NRD*AW)'($urandom);
            i_init_start = ($urandom_range(0, 3) == 0);
            step();
            n++;
            if (o_init_done) begin
                chk("init_done_cycle", 32'(n), 32'(exp_n));
                chk("words_loaded", 32'(idx), 32'(DEPTH));
                done = 1'b1;
            end else if (n > exp_n + 5) begin
                chk("load_timeout", 32'(n), 32'(exp_n));
                done = 1'b1;
            end else begin
                chk("mem_req", 32'(o_mem_req), 32'd1);
                chk("mem_addr", 32'(o_mem_addr), 32'(idx));
                if (abort_at >= 0 && idx == abort_at) begin
                    rst       = 1'b1;
                    i_mem_ack = 1'b0;
                    #1;
                    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
                    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
                    chk("rst_init_done", 32'(o_init_done), 32'd0);
                    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
                    chk("rst_rd_data", 32'(o_rd_data), 32'd0);
                    done = 1'b1;
                end else begin
                    c++;
                    if (c == k + 1) begin
                        c          = 0;
                        i_mem_ack  = 1'b1;
                        i_mem_data = base + DW'(idx);
                        model[idx] = base + DW'(idx);
                        idx++;
                    end else begin
                        i_mem_ack  = 1'b0;
                        i_mem_data = DW'($urandom);
                    end
                end
            end
        end
        i_mem_ack    = 1'b0;
        i_init_start = 1'b0;
        i_regfile_en = 1'b0;
        i_wr_en      = 1'b0;
        i_rd_en      = '0;
    endtask

    task automatic reload(input logic [DW-1:0] base, input int k, input int exp_n);
        i_init_start = 1'b1;
        drive(1'b1, 1'b1, AW'(2), 16'h5555, '0, '0, '0);
        i_init_start = 1'b0;
        in_work = 1'b0;
        chk("init_done_drop", 32'(o_init_done), 32'd0);
        do_load(base, k, exp_n, -1);
        in_work = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (3) step();
        chk("reset_mem_req", 32'(o_mem_req), 32'd0);
        chk("reset_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("reset_init_done", 32'(o_init_done), 32'd0);
        chk("reset_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("reset_rd_data", 32'(o_rd_data), 32'd0);

        rst = 1'b0;
        do_load(16'hA000, 0, DEPTH + 1, -1);
        in_work = 1'b1;

        // Port 0 reads address 5.
        drive(1'b1, 1'b0, '0, '0, 2'b01, AW'(5), '0);
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
        chk("model_a005", 32'(model[5]), 32'h0000A005);

        // Write-first bypass on port 0, old data on port 1.
        drive(1'b1, 1'b1, AW'(7), 16'h1234, 2'b11, AW'(7), AW'(8));
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);

        // Gated write and read, then enabled read of the same entry.
        drive(1'b0, 1'b1, AW'(3), 16'hBEEF, 2'b11, AW'(3), AW'(3));
        drive(1'b1, 1'b0, '0, '0, 2'b10, '0, AW'(3));
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);

        rand_traffic(200);

        // Reload with new contents, then read back address 5 and 2.
        reload(16'hB000, 0, DEPTH + 1);
        drive(1'b1, 1'b0, '0, '0, 2'b11, AW'(2), AW'(5));
        rand_traffic(150);

        // Reload with two wait cycles per word.
        reload(16'hD000, 2, 1 + DEPTH * 3);
        rand_traffic(100);

        // Reset in the middle of a reload, then a full load from reset.
        i_init_start = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
        i_init_start = 1'b0;
        in_work = 1'b0;
        do_load(16'hC000, 1, 1 + DEPTH * 2, 9);
        step();
        step();
        rst = 1'b0;
        do_load(16'hC000, 2, 1 + DEPTH * 3, -1);
        in_work = 1'b1;
        drive(1'b1, 1'b0, '0, '0, 2'b11, AW'(9), AW'(15));
        rand_traffic(150);

        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
        chk("drain_port0", 32'(g_mon[0].q.size()), 32'd0);
        chk("drain_port1", 32'(g_mon[1].q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
